// File: rtl/reg_file_dumper_if.sv
// Entry stream from the register-file dumper: one (index, value) pair per
// valid/ready handshake.
interface reg_file_dumper_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/reg_file_dumper.sv
// Debug read-out engine: on start, walks FIRST_REG..LAST_REG through a reg_file
// asynchronous read port and streams each (index, value) pair on a valid/ready port.
module reg_file_dumper #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [ADDR_W-1:0]   rf_a,
  input  logic [DATA_W-1:0]   rf_rd,
  reg_file_dumper_if.master   dump,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;

  // rf_a is registered so the read address is settled for the whole READ cycle;
  // the value captured at the end of READ reflects every write up to that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= FIRST_IDX;
      rf_a           <= '0;
      dump.out_valid <= 1'b0;
      dump.out_idx   <= '0;
      dump.out_data  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            idx   <= FIRST_IDX;
            rf_a  <= FIRST_IDX;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          if (abort) begin
            idx   <= FIRST_IDX;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dump.out_data  <= rf_rd;
            dump.out_idx   <= idx;
            dump.out_valid <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a same-cycle handshake: the entry is not taken.
          if (abort) begin
            dump.out_valid <= 1'b0;
            idx            <= FIRST_IDX;
            busy           <= 1'b0;
            state          <= IDLE;
          end else if (dump.out_ready) begin
            dump.out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + ADDR_W'(1);
              rf_a  <= idx + ADDR_W'(1);
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench for reg_file_dumper: a small reg_file model feeds the read port and
// a scoreboard queue holds the entries each dump is expected to stream.
module tb_reg_file_dumper;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_rd;
  logic              busy;
  logic              done;

  logic              we = 1'b0;
  logic [ADDR_W-1:0] wa = '0;
  logic [DATA_W-1:0] wd = '0;
  logic [DATA_W-1:0] regs   [NREG];
  logic [DATA_W-1:0] exp_rf [NREG];

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_taken  = 0;
  int     cyc      = 0;

  reg_file_dumper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

  reg_file_dumper #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIRST_REG(0), .LAST_REG(31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .rf_a  (rf_a),
    .rf_rd (rf_rd),
    .dump  (dif),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // reg_file model: x0 hardwired to zero, write lands at the rising edge.
  always @(posedge clk) begin
    if (we && wa != '0) regs[wa] <= wd;
  end
  assign rf_rd = regs[rf_a];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: an entry is taken when valid&&ready is seen without abort.
  always @(negedge clk) begin : mon
    entry_t e;
    if (rst_n && dif.out_valid && dif.out_ready && !abort) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_extra: entry idx %0d observed, expected no entry", dif.out_idx);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_idx", 32'(dif.out_idx), 32'(e.idx));
        check("sb_data", dif.out_data, e.data);
        n_taken++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    wa = ADDR_W'(a);
    wd = d;
    we = 1'b1;
    tick();
    we = 1'b0;
    if (a != 0) exp_rf[a] = d;
  endtask

  task automatic push_dump(input int ov_idx, input logic [31:0] ov_data);
    entry_t e;
    for (int i = 0; i < int'(NREG); i++) begin
      e.idx  = ADDR_W'(i);
      e.data = (i == ov_idx) ? ov_data : exp_rf[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int c;
    c = 0;
    while (!done && c < 300) begin
      tick();
      c++;
    end
    check(tag, 32'(cyc), 32'(exp_cyc));
    check("done_high", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    int t0;
    for (int i = 0; i < int'(NREG); i++) begin
      regs[i]   = '0;
      exp_rf[i] = '0;
    end
    dif.out_ready = 1'b1;

    // Reset values
    #1 rst_n = 1'b0;
    #10;
    check("rst_rf_a", 32'(rf_a), 32'd0);
    check("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check("rst_out_idx", 32'(dif.out_idx), 32'd0);
    check("rst_out_data", dif.out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // Full dump with preloads and an ignored write to x0
    write_reg(1, 32'd55);
    write_reg(2, 32'd99);
    write_reg(0, 32'd777);
    push_dump(-1, '0);
    t0 = n_taken;
    pulse_start();
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_valid_early", 32'(dif.out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(dif.out_valid), 32'd1);
    check("lat_idx0", 32'(dif.out_idx), 32'd0);
    check("lat_x0_zero", dif.out_data, 32'd0);
    wait_done("full_done_cycle", 64);
    check("full_count", 32'(n_taken - t0), 32'd32);

    // Consumer stall at idx 2
    push_dump(-1, '0);
    t0 = n_taken;
    pulse_start();
    c = 0;
    while (!(busy && !dif.out_valid && rf_a == 5'd2) && c < 20) begin
      tick();
      c++;
    end
    check("reach_read2", 32'(c < 20), 32'd1);
    dif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(dif.out_valid), 32'd1);
      check("stall_idx", 32'(dif.out_idx), 32'd2);
      check("stall_data", dif.out_data, 32'd99);
    end
    dif.out_ready = 1'b1;
    wait_done("stall_done_cycle", 68);
    check("stall_count", 32'(n_taken - t0), 32'd32);

    // Abort in SEND at idx 10, colliding with a handshake
    push_dump(-1, '0);
    t0 = n_taken;
    pulse_start();
    c = 0;
    while (!(dif.out_valid && dif.out_idx == 5'd10) && c < 40) begin
      tick();
      c++;
    end
    check("reach_send10", 32'(c < 40), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(dif.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    tick();
    check("abort_no_done2", 32'(done), 32'd0);
    check("abort_count", 32'(n_taken - t0), 32'd10);
    exp_q.delete();

    // start with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);

    // Write-visibility around the READ edges of idx 4 and 5
    push_dump(5, 32'd1234);
    t0 = n_taken;
    pulse_start();
    c = 0;
    while (!(dif.out_valid && dif.out_idx == 5'd4) && c < 40) begin
      tick();
      c++;
    end
    check("reach_send4", 32'(c < 40), 32'd1);
    wa = 5'd5;
    wd = 32'd1234;
    we = 1'b1;
    tick();
    wa = 5'd4;
    wd = 32'd42;
    tick();
    we = 1'b0;
    wait_done("rw_done_cycle", 64);
    check("rw_count", 32'(n_taken - t0), 32'd32);
    exp_rf[5] = 32'd1234;
    exp_rf[4] = 32'd42;

    // Restart attempt while busy, then async reset mid-dump at idx 7
    push_dump(-1, '0);
    t0 = n_taken;
    pulse_start();
    c = 0;
    while (!(dif.out_valid && dif.out_idx == 5'd3) && c < 40) begin
      tick();
      c++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!(busy && !dif.out_valid && rf_a == 5'd7) && c < 40) begin
      tick();
      c++;
    end
    check("reach_read7", 32'(c < 40), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("amid_rf_a", 32'(rf_a), 32'd0);
    check("amid_valid", 32'(dif.out_valid), 32'd0);
    check("amid_idx", 32'(dif.out_idx), 32'd0);
    check("amid_data", dif.out_data, 32'd0);
    check("amid_busy", 32'(busy), 32'd0);
    check("amid_done", 32'(done), 32'd0);
    check("amid_count", 32'(n_taken - t0), 32'd7);
    exp_q.delete();
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_no_done", 32'(done), 32'd0);

    // Clean dump after reset carries the earlier writes
    push_dump(-1, '0);
    t0 = n_taken;
    pulse_start();
    wait_done("final_done_cycle", 64);
    check("final_count", 32'(n_taken - t0), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
